// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises MEM-stage and DMA accesses onto one data-memory port.
// Latency: request seen in IDLE at T -> store ack at T+2, load ack at T+MEM_LAT+2.
// Backpressure: m_stall freezes the pipeline while m_req is pending; DMA holds d_req until d_ack.
module dmem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic          m_stall,
  output logic          m_ack,
  output logic [DW-1:0] m_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int LW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic            own_dma_q, own_dma_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            m_ack_q, m_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            grant;
  logic            grant_dma;

  // Next-state, arbitration, starvation tracking and registered-output decode
  always_comb begin
    state_d   = state_q;
    own_dma_d = own_dma_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    starve_d  = starve_q;
    m_rdata_d = m_rdata_q;
    d_rdata_d = d_rdata_q;

    // DMA only overtakes a pending MEM request once it has been passed over STARVE_MAX times
    grant     = (state_q == IDLE) && (m_req || d_req);
    grant_dma = grant && d_req && (!m_req || (starve_q == SW'(STARVE_MAX)));

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = ISSUE;
          own_dma_d = grant_dma;
          we_d      = grant_dma ? d_we    : m_we;
          addr_d    = grant_dma ? d_addr  : m_addr;
          wdata_d   = grant_dma ? d_wdata : m_wdata;
        end
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        wcnt_d  = LW'(MEM_LAT - 1);
      end
      WAIT: begin
        if (wcnt_q == '0) begin
          state_d = DONE;
          if (own_dma_q) d_rdata_d = mem_rdata;
          else           m_rdata_d = mem_rdata;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The counter only means something while DMA is actually waiting
    if (!d_req)
      starve_d = '0;
    else if (grant_dma)
      starve_d = '0;
    else if (grant && (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;

    mem_en_d = (state_d == ISSUE);
    m_ack_d  = (state_d == DONE) && !own_dma_d;
    d_ack_d  = (state_d == DONE) &&  own_dma_d;
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      own_dma_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
      starve_q  <= '0;
      m_rdata_q <= '0;
      d_rdata_q <= '0;
      mem_en_q  <= 1'b0;
      m_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_dma_q <= own_dma_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      starve_q  <= starve_d;
      m_rdata_q <= m_rdata_d;
      d_rdata_q <= d_rdata_d;
      mem_en_q  <= mem_en_d;
      m_ack_q   <= m_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  // Stall covers time queued behind DMA too; forced low during reset
  assign m_stall   = !rst && m_req && !((state_q == DONE) && !own_dma_q);
  assign m_ack     = m_ack_q;
  assign m_rdata   = m_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: drives MEM and DMA requesters against a latency-accurate memory model.
// Each cycle a transaction-level reference predicts grant order, strobes, acks, stall and read data.
// Directed scenarios first (reset, store, load, contention, starvation, mid-access reset), then random traffic.
module tb_dmem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_stall, m_ack;
  logic [DW-1:0] m_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_stall(m_stall), .m_ack(m_ack), .m_rdata(m_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h0000_00AB : 32'(32'h1000 + i * 17);
  endfunction

  // Memory: 16 words, read data appears LAT cycles after the strobe cycle
  logic [31:0] mem [16];
  logic [31:0] rd_pipe [LAT];
  bit          mem_ready;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one access at a time, t counts cycles since the grant (-1 = idle)
  int          t = -1;
  int          ack_t;
  bit          own_d;
  bit          c_we;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [31:0] exp_m_rd, exp_d_rd;
  int          starve;
  logic [31:0] ref_mem [16];
  bit          ref_init;
  bit          glog [$];
  int          en_cnt;
  bit          saw_m_ack, saw_d_ack;

  task automatic model_step();
    bit ack_now;
    if (!ref_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    saw_m_ack = m_ack;
    saw_d_ack = d_ack;
    if (mem_en) en_cnt++;
    if (rst) begin
      check_eq("rst_ctl", {m_stall, m_ack, d_ack, mem_en, mem_we}, 0);
      check_eq("rst_m_rdata", m_rdata, 0);
      check_eq("rst_d_rdata", d_rdata, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      t = -1; starve = 0; exp_m_rd = '0; exp_d_rd = '0;
      return;
    end
    ack_now = (t >= 0) && (t == ack_t);
    check_eq("mem_en", mem_en, t == 1);
    if (t == 1) begin
      check_eq("mem_we", mem_we, c_we);
      check_eq("mem_addr", mem_addr, c_addr);
      check_eq("mem_wdata", mem_wdata, c_wdata);
    end
    check_eq("m_ack", m_ack, ack_now && !own_d);
    check_eq("d_ack", d_ack, ack_now && own_d);
    check_eq("m_stall", m_stall, m_req && !(ack_now && !own_d));
    if (ack_now && !c_we) begin
      if (own_d) exp_d_rd = c_rdata;
      else       exp_m_rd = c_rdata;
    end
    check_eq("m_rdata", m_rdata, exp_m_rd);
    check_eq("d_rdata", d_rdata, exp_d_rd);

    if (ack_now) begin
      t = -1;
    end else if (t >= 0) begin
      t++;
    end else if (m_req || d_req) begin
      own_d   = d_req && (!m_req || starve == SMAX);
      c_we    = own_d ? d_we    : m_we;
      c_addr  = own_d ? d_addr  : m_addr;
      c_wdata = own_d ? d_wdata : m_wdata;
      ack_t   = c_we ? 2 : LAT + 2;
      if (c_we) ref_mem[c_addr[3:0]] = c_wdata;
      else      c_rdata = ref_mem[c_addr[3:0]];
      glog.push_back(own_d);
      if (own_d)      starve = 0;
      else if (d_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
      t = 1;
    end
    if (!d_req) starve = 0;
  endtask

  // Check the current cycle mid-period, then return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dma, output int k);
    bit done;
    k = 0;
    done = 1'b0;
    while (!done) begin
      tick();
      if (dma ? saw_d_ack : saw_m_ack) begin
        done = 1'b1;
      end else begin
        k++;
        if (k > 60) begin
          check_eq(dma ? "d_ack_timeout" : "m_ack_timeout", 0, 1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int k, km, kd, nd;
    rst = 1'b1;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset held two cycles, then ten quiet cycles
    tick(); tick();
    rst = 1'b0;
    en_cnt = 0;
    repeat (10) tick();
    check_eq("quiet_no_mem_en", en_cnt, 0);

    // MEM store: addr 9, data 99
    m_req = 1; m_we = 1; m_addr = 9; m_wdata = 99;
    wait_ack(1'b0, k);
    check_eq("store_lat", k, 2);
    m_req = 0;
    tick();

    // MEM load from addr 9 returns 99
    m_req = 1; m_we = 0; m_addr = 9;
    wait_ack(1'b0, k);
    check_eq("load_lat", k, LAT + 2);
    check_eq("load_data", m_rdata, 32'h63);
    m_req = 0;
    repeat (3) tick();
    check_eq("load_data_held", m_rdata, 32'h63);

    // Simultaneous requests: MEM store first, then DMA load of addr 4
    m_req = 1; m_we = 1; m_addr = 2; m_wdata = 32'h5555;
    d_req = 1; d_we = 0; d_addr = 4; d_wdata = 32'h7777;
    km = -1; kd = -1;
    for (int i = 0; i < 60 && kd < 0; i++) begin
      tick();
      if (saw_m_ack && km < 0) begin km = i; m_req = 0; end
      if (saw_d_ack) begin kd = i; d_req = 0; end
    end
    check_eq("contend_m_lat", km, 2);
    check_eq("contend_d_lat", kd, 2 + 1 + LAT + 2);
    check_eq("contend_d_data", d_rdata, 32'hAB);
    check_eq("contend_m_data_kept", m_rdata, 32'h63);
    tick();

    // Starvation: MEM always re-requesting, DMA held across two accesses
    glog.delete();
    m_req = 1; m_we = 1; m_addr = 1; m_wdata = $urandom;
    d_req = 1; d_we = 0; d_addr = 5;
    nd = 0;
    for (int i = 0; i < 200 && nd < 2; i++) begin
      tick();
      if (saw_m_ack) m_wdata = $urandom;
      if (saw_d_ack) nd++;
    end
    m_req = 0; d_req = 0;
    tick(); tick();
    check_eq("starve_grants", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      check_eq($sformatf("starve_grant%0d", i), glog[i], (i == 4 || i == 9));

    // Reset during the WAIT of a MEM load, request kept high across it
    m_req = 1; m_we = 0; m_addr = 9;
    tick(); tick();
    rst = 1'b1;
    tick();
    check_eq("abort_rdata_cleared", m_rdata, 0);
    rst = 1'b0;
    wait_ack(1'b0, k);
    check_eq("reissue_lat", k, LAT + 2);
    check_eq("reissue_data", m_rdata, 32'h63);
    m_req = 0;
    tick();

    // Random traffic from both requesters
    for (int c = 0; c < 2500; c++) begin
      if (m_req && saw_m_ack) m_req = 0;
      else if (m_req && $urandom_range(0, 39) == 0) m_req = 0;
      else if (m_req && $urandom_range(0, 5) == 0) begin
        m_addr = 32'($urandom_range(0, 15)); m_wdata = $urandom;
      end
      if (!m_req && $urandom_range(0, 2) == 0) begin
        m_req = 1; m_we = 1'($urandom_range(0, 1));
        m_addr = 32'($urandom_range(0, 15)); m_wdata = $urandom;
      end
      if (d_req && saw_d_ack) d_req = 0;
      else if (d_req && $urandom_range(0, 39) == 0) d_req = 0;
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)); d_wdata = $urandom;
      end
      tick();
    end
    m_req = 0; d_req = 0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
